atan_ratio_div: RTL

Upstream stage of the atan unit. Takes a signed vector (x, y), computes z = y/x as a serial restoring division, and saturates z to the atan input range of ±255. It presents z as signed Q8.8 on the atan para_in bus and fires a one-cycle trigger to start the atan unit. It then holds off until atan reports vld, so every ratio it produces is consumed exactly once.

---
 rtl/atan_ratio_div_if.sv | 23 ++
 rtl/atan_ratio_div.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/atan_ratio_div_if.sv
// Request/response bus between the vector source, the ratio divider and the atan unit.
// The slave side is the divider; the master side drives requests and the atan vld.
interface atan_ratio_div_if #(
    parameter int IN_W = 12
);
    logic            start;
    logic [IN_W-1:0] x_in;
    logic [IN_W-1:0] y_in;
    logic            ds_vld;
    logic            busy;
    logic            trig_out;
    logic [16:0]     ratio_out;

    modport master (
        output start, x_in, y_in, ds_vld,
        input  busy, trig_out, ratio_out
    );

    modport slave (
        input  start, x_in, y_in, ds_vld,
        output busy, trig_out, ratio_out
    );
endinterface

// File: rtl/atan_ratio_div.sv
// Serial restoring divider producing z = y/x as saturated signed Q8.8 for the atan unit,
// then triggering atan once and holding off until atan reports vld.
module atan_ratio_div #(
    parameter int IN_W    = 12,
    parameter int FRAC_W  = 8,
    parameter int SAT_MAG = 65280
) (
    input logic              clk,
    input logic              rst_n,
    atan_ratio_div_if.slave  io
);
    localparam int N     = IN_W + FRAC_W;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [N-1:0] SAT_Q  = N'(SAT_MAG);
    localparam logic [16:0]  SAT_R  = 17'(SAT_MAG);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIV  = 3'd1,
        SAT  = 3'd2,
        TRIG = 3'd3,
        WAIT = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sx_q;
    logic             xz_q;
    logic             yz_q;
    logic [IN_W-1:0]  dvs_q;
    logic [IN_W-1:0]  rem_q;
    logic [N-1:0]     quo_q;
    logic [16:0]      ratio_q;
    logic             trig_q;

    logic [IN_W:0]    trial_s;
    logic [IN_W-1:0]  rem_d;
    logic             qbit_s;
    logic [16:0]      mag_s;
    logic             neg_s;
    logic [16:0]      ratio_d;

    // The most negative input maps to 2^(IN_W-1), which still fits IN_W unsigned bits.
    function automatic logic [IN_W-1:0] abs_f(input logic [IN_W-1:0] v);
        if (v[IN_W-1]) begin
            return ~v + IN_W'(1);
        end else begin
            return v;
        end
    endfunction

    // One restoring step; quo_q shifts dividend bits out the top and quotient bits in the bottom.
    always_comb begin
        trial_s = {rem_q, quo_q[N-1]};
        if (trial_s >= {1'b0, dvs_q}) begin
            rem_d  = trial_s[IN_W-1:0] - dvs_q;
            qbit_s = 1'b1;
        end else begin
            rem_d  = trial_s[IN_W-1:0];
            qbit_s = 1'b0;
        end
    end

    // Saturation and sign restore; 0/0 is forced to a positive zero.
    always_comb begin
        if (xz_q) begin
            if (yz_q) begin
                mag_s = 17'd0;
            end else begin
                mag_s = SAT_R;
            end
        end else if (quo_q > SAT_Q) begin
            mag_s = SAT_R;
        end else begin
            mag_s = quo_q[16:0];
        end
        neg_s = sx_q & ~(xz_q & yz_q);
        if (neg_s) begin
            ratio_d = ~mag_s + 17'd1;
        end else begin
            ratio_d = mag_s;
        end
    end

    // Control FSM with registered ratio and trigger outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sx_q    <= 1'b0;
            xz_q    <= 1'b0;
            yz_q    <= 1'b0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            ratio_q <= 17'd0;
            trig_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    trig_q <= 1'b0;
                    if (io.start) begin
                        state_q <= DIV;
                        cnt_q   <= CNT_W'(N);
                        sx_q    <= io.x_in[IN_W-1] ^ io.y_in[IN_W-1];
                        xz_q    <= (io.x_in == '0);
                        yz_q    <= (io.y_in == '0);
                        dvs_q   <= abs_f(io.x_in);
                        rem_q   <= '0;
                        quo_q   <= {abs_f(io.y_in), {FRAC_W{1'b0}}};
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[N-2:0], qbit_s};
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= SAT;
                    end
                end
                SAT: begin
                    ratio_q <= ratio_d;
                    trig_q  <= 1'b1;
                    state_q <= TRIG;
                end
                TRIG: begin
                    trig_q  <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (io.ds_vld) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    trig_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io.busy      = (state_q != IDLE);
    assign io.trig_out  = trig_q;
    assign io.ratio_out = ratio_q;
endmodule
